mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 The block SHALL have parameter n, default 8, giving the data width of each requester and of Y.
REQ-002 The block SHALL have parameter MAX_BURST, default 4, giving the maximum beats per grant (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-005 The block SHALL have ports A, B, C and D, input, n bits each, the requester data for requesters 0, 1, 2 and 3.
REQ-006 The block SHALL have port req, input, 4 bits, where bit i is high while requester i has data to send.
REQ-007 The block SHALL have port y_ready, input, 1 bit, the downstream consumer's readiness.
REQ-008 The block SHALL have port gnt, output, 4 bits, the registered one-hot-or-zero grant.
REQ-009 The block SHALL have port S, output, 2 bits, the mux select equal to the granted index.
REQ-010 The block SHALL have port ack, output, 4 bits, where bit i pulses for one cycle when requester i's data is captured.
REQ-011 The block SHALL have ports Y (output, n bits, registered output data) and y_valid (output, 1 bit, Y holds an unconsumed beat).

Function
REQ-012 The block SHALL implement states IDLE and GRANT, with a 2-bit round-robin pointer ptr and a 4-bit beat counter cnt.
REQ-013 In IDLE with req nonzero, the block SHALL register gnt for the first set req bit at or after ptr in the order ptr, ptr+1, ... mod 4, set S to that index and enter GRANT on the next edge, giving one-cycle arbitration latency.
REQ-014 In IDLE with req equal to 0, the block SHALL keep gnt at 0 and hold S.
REQ-015 In GRANT for granted index g, a beat SHALL occur on each cycle where req[g] is 1 and (y_valid is 0 or y_ready is 1); on a beat Y loads the selected data (A/B/C/D per S), y_valid is set to 1, ack[g] is 1 and cnt increments.
REQ-016 When y_ready is 1 and no beat occurs, y_valid SHALL clear on the next edge; when y_ready is 0, Y and y_valid SHALL hold.
REQ-017 GRANT SHALL end when req[g] is sampled as 0, or on the edge of the beat that makes cnt equal MAX_BURST; gnt then goes to 0, ptr becomes g+1 mod 4, cnt clears and the state returns to IDLE.
REQ-018 At least one IDLE cycle SHALL separate consecutive grants, and a sole requester SHALL be regranted after that cycle.
REQ-019 gnt SHALL never have more than one bit set, and ack SHALL only be asserted on the bit set in gnt.
REQ-020 Changes on req of non-granted requesters SHALL have no effect during GRANT.

Reset
REQ-021 Assertion of rst_n low SHALL immediately force gnt=0, ack=0, S=0, Y=0, y_valid=0, ptr=0, cnt=0 and state IDLE, including mid-burst; any pending beat is discarded.
REQ-022 After rst_n rises, the first arbitration SHALL start from requester 0.

Configuration
REQ-023 With macro MUX4_ARB_LOCK_EN defined, the block SHALL add input port lock (1 bit); while lock is 1 in GRANT, the MAX_BURST limit is ignored and the grant ends only when req[g] goes to 0.
REQ-024 Without MUX4_ARB_LOCK_EN, the block SHALL have no lock port and MAX_BURST SHALL always apply.

Verification
REQ-025 A=8'hAA, req=4'b0001, y_ready=1 for 6 cycles -> gnt=0001, S=0, Y=8'hAA, four acks, then one cycle with gnt=0, then regrant to requester 0.
REQ-026 req=4'b1111 held, y_ready=1, with A=8'hAA, B=8'h66, C=8'hDD, D=8'h11 -> grants in the order 0,1,2,3,0, each delivering 4 beats with Y matching the granted data.
REQ-027 req=4'b0010 with B=8'h66, y_ready=0 -> exactly one beat, y_valid=1, Y=8'h66 held, ack low; y_ready raised -> beats resume.
REQ-028 req[2] dropped after 2 beats while C=8'hDD -> gnt clears next edge, ptr=3, and the next grant goes to D (8'h11) ahead of A.
REQ-029 rst_n pulled low mid-burst -> all outputs are zero asynchronously; after release with req=4'b1100 -> grant goes to requester 2.
REQ-030 With MUX4_ARB_LOCK_EN and lock=1, req=4'b0011 -> requester 0 is granted for 10 or more beats; lock dropped -> the grant ends at MAX_BURST and requester 1 is granted.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ==========================================================================
// mux4_rr_arbiter : round-robin 4:1 arbitrating mux, burst-limited grants,
//                   registered valid/ready output. Option: MUX4_ARB_LOCK_EN
// Revision 1.0
// ==========================================================================
module mux4_rr_arbiter #(
  parameter int n         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic [n-1:0] C,
  input  logic [n-1:0] D,
  input  logic [3:0]   req,
  input  logic         y_ready,
`ifdef MUX4_ARB_LOCK_EN
  input  logic         lock,
`endif
  output logic [3:0]   gnt,
  output logic [1:0]   S,
  output logic [3:0]   ack,
  output logic [n-1:0] Y,
  output logic         y_valid
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [4:0] c_max_burst = 5'(MAX_BURST);

  state_t       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   gnt_q, gnt_d;
  logic [1:0]   s_q, s_d;
  logic [n-1:0] y_q, y_d;
  logic         yv_q, yv_d;

  logic [1:0]   pick;
  logic [1:0]   cand;
  logic         found;
  logic         beat;
  logic         last_beat;
  logic         lock_w;
  logic [n-1:0] sel_data;

`ifdef MUX4_ARB_LOCK_EN
  assign lock_w = lock;
`else
  assign lock_w = 1'b0;
`endif

  // Search starts at ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin
    pick  = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    case (s_q)
      2'd0:    sel_data = A;
      2'd1:    sel_data = B;
      2'd2:    sel_data = C;
      default: sel_data = D;
    endcase
  end

  assign beat      = (state_q == GRANT) && req[s_q] && (!yv_q || y_ready);
  assign last_beat = beat && !lock_w && (({1'b0, cnt_q} + 5'd1) >= c_max_burst);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    y_d     = y_q;
    yv_d    = yv_q;

    if (beat) begin
      y_d  = sel_data;
      yv_d = 1'b1;
    end else if (y_ready) begin
      yv_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = 4'b0001 << pick;
          s_d     = pick;
          cnt_d   = '0;
          state_d = GRANT;
        end else begin
          gnt_d = '0;
        end
      end
      GRANT: begin
        if (!req[s_q] || last_beat) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = s_q + 2'd1;
          cnt_d   = '0;
        end else if (beat && (cnt_q != 4'hF)) begin
          // Saturate so a long locked burst cannot wrap past the limit.
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      s_q     <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
    end
  end

  assign gnt     = gnt_q;
  assign S       = s_q;
  assign ack     = gnt_q & {4{beat}};
  assign Y       = y_q;
  assign y_valid = yv_q;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// Testbench for mux4_rr_arbiter: per-cycle vector table, expected outputs
// queued on drive and compared at the falling edge.
module tb_mux4_rr_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] A, B, C, D;
  logic [3:0]   req;
  logic         y_ready;
`ifdef MUX4_ARB_LOCK_EN
  logic         lock;
`endif
  logic [3:0]   gnt, ack;
  logic [1:0]   S;
  logic [N-1:0] Y;
  logic         y_valid;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.n(N), .MAX_BURST(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .C       (C),
    .D       (D),
    .req     (req),
    .y_ready (y_ready),
`ifdef MUX4_ARB_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .S       (S),
    .ack     (ack),
    .Y       (Y),
    .y_valid (y_valid)
  );

  typedef struct {
    logic         rst;
    logic         lk;
    logic [3:0]   req;
    logic         rdy;
    logic [N-1:0] a, b, c, d;
    logic [3:0]   gnt;
    logic [1:0]   s;
    logic [3:0]   ack;
    logic [N-1:0] y;
    logic         yv;
  } vec_t;

  typedef struct {
    logic [3:0]   gnt;
    logic [1:0]   s;
    logic [3:0]   ack;
    logic [N-1:0] y;
    logic         yv;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [N-1:0] cur_a, cur_b, cur_c, cur_d;
  logic         cur_rst, cur_lk;

  function automatic void add(input logic [3:0] rq, input logic rdy,
                              input logic [3:0] g, input logic [1:0] s,
                              input logic [3:0] ak, input logic [N-1:0] y,
                              input logic yv);
    vec_t v;
    v.rst = cur_rst; v.lk = cur_lk; v.req = rq; v.rdy = rdy;
    v.a = cur_a; v.b = cur_b; v.c = cur_c; v.d = cur_d;
    v.gnt = g; v.s = s; v.ack = ak; v.y = y; v.yv = yv;
    tbl.push_back(v);
    cur_rst = 1'b0;
  endfunction

  task automatic chk(input int idx, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL row %0d %s: got %0h expected %0h", idx, nm, act, exp);
    end
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk(-1, "rst_gnt", 32'(gnt), 32'd0);
    chk(-1, "rst_S",   32'(S),   32'd0);
    chk(-1, "rst_ack", 32'(ack), 32'd0);
    chk(-1, "rst_Y",   32'(Y),   32'd0);
    chk(-1, "rst_yv",  32'(y_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input vec_t v, input int idx);
    exp_t e;
    req = v.req; y_ready = v.rdy;
    A = v.a; B = v.b; C = v.c; D = v.d;
`ifdef MUX4_ARB_LOCK_EN
    lock = v.lk;
`endif
    e.gnt = v.gnt; e.s = v.s; e.ack = v.ack; e.y = v.y; e.yv = v.yv;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk(idx, "gnt",     32'(gnt),     32'(e.gnt));
    chk(idx, "S",       32'(S),       32'(e.s));
    chk(idx, "ack",     32'(ack),     32'(e.ack));
    chk(idx, "Y",       32'(Y),       32'(e.y));
    chk(idx, "y_valid", 32'(y_valid), 32'(e.yv));
    chk(idx, "gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    chk(idx, "ack_in_gnt",  32'((ack & ~gnt) == 4'd0), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [N-1:0] dv [4];
    logic [N-1:0] prev_y;
    logic [1:0]   prev_s;
    logic [3:0]   g;

    rst_n = 1'b0; req = '0; y_ready = 1'b0;
    A = '0; B = '0; C = '0; D = '0;
`ifdef MUX4_ARB_LOCK_EN
    lock = 1'b0;
`endif
    cur_a = 8'hAA; cur_b = 8'h66; cur_c = 8'hDD; cur_d = 8'h11;
    cur_rst = 1'b0; cur_lk = 1'b0;
    dv[0] = 8'hAA; dv[1] = 8'h66; dv[2] = 8'hDD; dv[3] = 8'h11;

    // Sole requester 0: four beats, one idle cycle, regrant.
    cur_rst = 1'b1;
    add(4'h1, 1, 4'h0, 0, 4'h0, 8'h00, 0);
    add(4'h1, 1, 4'h1, 0, 4'h1, 8'h00, 0);
    repeat (3) add(4'h1, 1, 4'h1, 0, 4'h1, 8'hAA, 1);
    add(4'h1, 1, 4'h0, 0, 4'h0, 8'hAA, 1);
    add(4'h1, 1, 4'h1, 0, 4'h1, 8'hAA, 0);
    add(4'h0, 1, 4'h1, 0, 4'h0, 8'hAA, 1);
    add(4'h0, 1, 4'h0, 0, 4'h0, 8'hAA, 0);

    // All four requesting: rotation 0,1,2,3,0 with four beats each.
    cur_rst = 1'b1;
    prev_y = 8'h00; prev_s = 2'd0;
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      add(4'hF, 1, 4'h0, prev_s, 4'h0, prev_y, (k != 0));
      add(4'hF, 1, g, 2'(k % 4), g, prev_y, 0);
      repeat (3) add(4'hF, 1, g, 2'(k % 4), g, dv[k % 4], 1);
      prev_y = dv[k % 4];
      prev_s = 2'(k % 4);
    end

    // Requester 1 with downstream stalled: one beat then hold.
    cur_rst = 1'b1;
    add(4'h2, 0, 4'h0, 0, 4'h0, 8'h00, 0);
    add(4'h2, 0, 4'h2, 1, 4'h2, 8'h00, 0);
    cur_b = 8'h5A;
    repeat (2) add(4'h2, 0, 4'h2, 1, 4'h0, 8'h66, 1);
    cur_b = 8'h66;
    repeat (3) add(4'h2, 1, 4'h2, 1, 4'h2, 8'h66, 1);
    add(4'h2, 1, 4'h0, 1, 4'h0, 8'h66, 1);
    add(4'h2, 1, 4'h2, 1, 4'h2, 8'h66, 0);

    // Requester 2 drops after two beats; D wins over A next.
    cur_rst = 1'b1;
    add(4'h4, 1, 4'h0, 0, 4'h0, 8'h00, 0);
    add(4'h4, 1, 4'h4, 2, 4'h4, 8'h00, 0);
    add(4'h7, 1, 4'h4, 2, 4'h4, 8'hDD, 1);
    add(4'h9, 1, 4'h4, 2, 4'h0, 8'hDD, 1);
    add(4'h9, 1, 4'h0, 2, 4'h0, 8'hDD, 0);
    add(4'h9, 1, 4'h8, 3, 4'h8, 8'hDD, 0);
    add(4'h9, 1, 4'h8, 3, 4'h8, 8'h11, 1);

    // Reset lands mid-burst of requester 3; arbitration restarts at 0.
    cur_rst = 1'b1;
    add(4'hC, 1, 4'h0, 0, 4'h0, 8'h00, 0);
    add(4'hC, 1, 4'h4, 2, 4'h4, 8'h00, 0);
    add(4'hC, 1, 4'h4, 2, 4'h4, 8'hDD, 1);

`ifdef MUX4_ARB_LOCK_EN
    // Locked grant runs past MAX_BURST until lock drops.
    cur_rst = 1'b1; cur_lk = 1'b1;
    add(4'h3, 1, 4'h0, 0, 4'h0, 8'h00, 0);
    add(4'h3, 1, 4'h1, 0, 4'h1, 8'h00, 0);
    repeat (11) add(4'h3, 1, 4'h1, 0, 4'h1, 8'hAA, 1);
    cur_lk = 1'b0;
    add(4'h3, 1, 4'h1, 0, 4'h1, 8'hAA, 1);
    add(4'h3, 1, 4'h0, 0, 4'h0, 8'hAA, 1);
    add(4'h3, 1, 4'h2, 1, 4'h2, 8'hAA, 0);
`endif

    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i], i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
